gb_framebuffer: RTL and testbench
=================================

// Module: gb_framebuffer
// PURPOSE
// Double-buffered 160x144 2bpp frame store between the PPU pixel stream and the VGA/LCD scanout.
// PPU writes pixels sequentially into the back bank. Scanout reads the front bank by {py,px} address.
// Reads return 24-bit colour, packed {B,G,R}, one cycle after the address, via a 4-entry palette.
// Banks swap only at a scanout frame boundary, so the display never tears.
// PARAMETERS
// GB_W      160        active width in pixels; x counter wraps at GB_W-1
// GB_H      144        active height in lines; last line is GB_H-1
// PAL0      24'hE0F8D0 colour for pixel code 0 ({B,G,R} byte order, R in [7:0])
// PAL1      24'h88C070 colour for pixel code 1
// PAL2      24'h346856 colour for pixel code 2
// PAL3      24'h201808 colour for pixel code 3
// BORDER    24'h000000 colour returned for addresses outside GB_W x GB_H
// PORTS
// pixelClock     in   1   single clock for both write and read sides
// reset          in   1   synchronous, active-high
// frame_start    in   1   1-cycle pulse from PPU: next valid pixel is (0,0)
// pix_valid      in   1   pix_data is a pixel to store this cycle
// pix_data       in   2   2bpp colour code
// rd_frame_start in   1   1-cycle pulse from scanout at start of its vertical blank
// va             in   16  read address {py[7:0],px[7:0]}
// vd             out  24  palette colour for va from the previous cycle
// ppu_addr       out  16  {y[7:0],x[7:0]} of the next pixel the writer will store
// frame_ready    out  1   back bank holds a complete frame awaiting swap
// disp_bank      out  1   bank currently shown by scanout
// dropped        out  8   saturating count of completed frames overwritten before display
// BEHAVIOUR
// - Reset values: vd=0, ppu_addr=0, frame_ready=0, disp_bank=0, dropped=0, writer FSM=IDLE.
// - Reset mid-frame discards partial data. RAM contents are not cleared.
// - Storage: 2 banks x GB_W*GB_H x 2 bits.
//   - Linear index = y*160 + x, computed as (y<<7)+(y<<5)+x in 15 bits; no multiplier.
//   - Write bank is always ~disp_bank.
// - Writer FSM:
//   - IDLE: ignore pix_valid. frame_start -> WRITE with x=0, y=0.
//   - WRITE: on pix_valid, store pix_data at (x,y).
//     - If x==GB_W-1: x<=0, y<=y+1. Otherwise x<=x+1.
//     - Store at (GB_W-1, GB_H-1) -> DONE and frame_ready<=1 on the next cycle.
//   - DONE: ignore pix_valid; x/y hold at GB_W-1/GB_H-1. frame_start -> WRITE.
//   - frame_start in any state (including during WRITE) restarts at (0,0). A partial frame never sets frame_ready.
// - Drop rule: frame_start while frame_ready=1 and no swap in the same cycle:
//   - frame_ready<=0 and dropped<=dropped+1 (saturate at 255).
//   - Writer overwrites the same back bank.
// - Swap: rd_frame_start with frame_ready=1 -> disp_bank toggles, frame_ready<=0.
//   - rd_frame_start with frame_ready=0 has no effect.
// - Simultaneous rd_frame_start and frame_start with frame_ready=1:
//   - Swap happens; no drop is counted.
//   - Writer starts into the new back bank, which is the old front bank.
// - Simultaneous frame completion and rd_frame_start: no swap this cycle; frame_ready rises next cycle.
// - ppu_addr = {y,x} of the writer's current position, registered, updated the cycle after each store.
// - Read path, latency exactly 1 cycle:
//   - vd(t+1) = palette[front[va(t)]] if px<GB_W and py<GB_H, else BORDER.
//   - Read address is always computed against disp_bank as sampled at cycle t.
//   - A write to the back bank never affects vd.
// - No backpressure on either side: pix_valid is accepted every cycle; va is read every cycle.
// TESTING
// - Reset, then va=16'h0000 with no frame written -> vd=24'h000000 on the first cycle after reset, and disp_bank=0.
// - Write one full frame (23040 pix_valid) with code = x[1:0] -> frame_ready=1 one cycle after the last store.
//   - Then pulse rd_frame_start -> disp_bank=1; va={8'd0,8'd3} -> vd=PAL3 next cycle.
// - va={8'd143,8'd160} and va={8'd144,8'd0} -> vd=BORDER. va={8'd143,8'd159} -> palette of the stored pixel.
// - Complete frame, then frame_start with no rd_frame_start -> dropped=1, frame_ready=0, disp_bank unchanged.
// - Pulse frame_start after 500 pixels, then write a full frame -> (0,0) holds the new data and exactly one frame_ready rise.
// - Same-cycle rd_frame_start and frame_start with frame_ready=1 -> disp_bank toggles, dropped unchanged, next pixel writes bank ~disp_bank.

Source files
------------

// File: rtl/gb_framebuffer.sv
// gb_framebuffer: double-buffered 160x144 2bpp frame store.
// The PPU writer fills the back bank pixel by pixel; scanout reads the front
// bank through a 4-entry palette with one cycle of latency. Banks swap only
// when scanout signals a frame boundary and a complete frame is waiting.
module gb_framebuffer #(
   parameter int          GB_W   = 160,
   parameter int          GB_H   = 144,
   parameter logic [23:0] PAL0   = 24'hE0F8D0,
   parameter logic [23:0] PAL1   = 24'h88C070,
   parameter logic [23:0] PAL2   = 24'h346856,
   parameter logic [23:0] PAL3   = 24'h201808,
   parameter logic [23:0] BORDER = 24'h000000
) (
   input  logic        pixelClock,
   input  logic        reset,
   input  logic        frame_start,
   input  logic        pix_valid,
   input  logic [1:0]  pix_data,
   input  logic        rd_frame_start,
   input  logic [15:0] va,
   output logic [23:0] vd,
   output logic [15:0] ppu_addr,
   output logic        frame_ready,
   output logic        disp_bank,
   output logic [7:0]  dropped
);

   localparam int         DEPTH  = GB_W * GB_H;
   localparam logic [7:0] X_LAST = 8'(GB_W - 1);
   localparam logic [7:0] Y_LAST = 8'(GB_H - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } wr_state_t;

   wr_state_t   state_reg, state_next;
   logic [7:0]  x_reg, x_next;
   logic [7:0]  y_reg, y_next;
   logic        frame_ready_reg, frame_ready_next;
   logic        disp_bank_reg, disp_bank_next;
   logic [7:0]  dropped_reg, dropped_next;
   logic        wr_en;
   logic        frame_done;
   logic        swap;
   logic [14:0] wr_idx;

   logic [7:0]  rd_px, rd_py;
   logic        rd_in_range;
   logic [14:0] rd_idx;
   logic        rd_live_reg;
   logic        rd_in_range_reg;
   logic        rd_bank_reg;
   logic [1:0]  rd_code;

   // y*160 + x built from shifts so no multiplier is needed
   function automatic logic [14:0] lin_index(input logic [7:0] y, input logic [7:0] x);
      logic [14:0] yw;
      yw = {7'b0, y};
      return (yw << 7) + (yw << 5) + {7'b0, x};
   endfunction

   function automatic logic [23:0] palette(input logic [1:0] code);
      case (code)
         2'd0:    return PAL0;
         2'd1:    return PAL1;
         2'd2:    return PAL2;
         default: return PAL3;
      endcase
   endfunction

   assign wr_idx = lin_index(y_reg, x_reg);

   // Writer position, bank swap and drop bookkeeping for the next cycle
   always_comb begin
      state_next       = state_reg;
      x_next           = x_reg;
      y_next           = y_reg;
      frame_ready_next = frame_ready_reg;
      disp_bank_next   = disp_bank_reg;
      dropped_next     = dropped_reg;
      wr_en            = 1'b0;
      frame_done       = 1'b0;
      swap             = rd_frame_start && frame_ready_reg;

      // A frame_start pulse wins over any pixel in the same cycle
      if (frame_start) begin
         state_next = WRITE;
         x_next     = 8'd0;
         y_next     = 8'd0;
      end else begin
         case (state_reg)
            WRITE: begin
               if (pix_valid) begin
                  wr_en = 1'b1;
                  if (x_reg == X_LAST) begin
                     if (y_reg == Y_LAST) begin
                        // Position holds on the last pixel while DONE
                        state_next = DONE;
                        frame_done = 1'b1;
                     end else begin
                        x_next = 8'd0;
                        y_next = y_reg + 8'd1;
                     end
                  end else begin
                     x_next = x_reg + 8'd1;
                  end
               end
            end
            default: ;
         endcase
      end

      if (swap) begin
         disp_bank_next   = ~disp_bank_reg;
         frame_ready_next = 1'b0;
      end else if (frame_start && frame_ready_reg) begin
         // Completed frame is discarded; writer reuses the same back bank
         frame_ready_next = 1'b0;
         if (dropped_reg != 8'hFF) begin
            dropped_next = dropped_reg + 8'd1;
         end
      end

      if (frame_done) begin
         frame_ready_next = 1'b1;
      end
   end

   // Control state register
   always_ff @(posedge pixelClock) begin
      if (reset) begin
         state_reg       <= IDLE;
         x_reg           <= 8'd0;
         y_reg           <= 8'd0;
         frame_ready_reg <= 1'b0;
         disp_bank_reg   <= 1'b0;
         dropped_reg     <= 8'd0;
      end else begin
         state_reg       <= state_next;
         x_reg           <= x_next;
         y_reg           <= y_next;
         frame_ready_reg <= frame_ready_next;
         disp_bank_reg   <= disp_bank_next;
         dropped_reg     <= dropped_next;
      end
   end

   assign rd_px       = va[7:0];
   assign rd_py       = va[15:8];
   assign rd_in_range = (32'(rd_px) < GB_W) && (32'(rd_py) < GB_H);
   assign rd_idx      = rd_in_range ? lin_index(rd_py, rd_px) : 15'd0;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         logic [1:0] mem [0:DEPTH-1];
         logic [1:0] q;

         // Bank storage: writes only when this is the back bank, registered read
         always_ff @(posedge pixelClock) begin
            if (wr_en && (disp_bank_reg != 1'(gi))) begin
               mem[wr_idx] <= pix_data;
            end
            q <= mem[rd_idx];
         end
      end
   endgenerate

   // Read-side pipeline: remember which bank and whether the address was on screen
   always_ff @(posedge pixelClock) begin
      if (reset) begin
         rd_live_reg     <= 1'b0;
         rd_in_range_reg <= 1'b0;
         rd_bank_reg     <= 1'b0;
      end else begin
         rd_live_reg     <= 1'b1;
         rd_in_range_reg <= rd_in_range;
         rd_bank_reg     <= disp_bank_reg;
      end
   end

   assign rd_code = rd_bank_reg ? g_bank[1].q : g_bank[0].q;

   // Colour output; forced to zero until the first read after reset
   always_comb begin
      vd = 24'h000000;
      if (rd_live_reg) begin
         vd = rd_in_range_reg ? palette(rd_code) : BORDER;
      end
   end

   assign ppu_addr    = {y_reg, x_reg};
   assign frame_ready = frame_ready_reg;
   assign disp_bank   = disp_bank_reg;
   assign dropped     = dropped_reg;

endmodule

// File: tb/tb_gb_framebuffer.sv
// tb_gb_framebuffer: randomized scenarios checked against a frame-level
// model holding both banks as plain arrays plus the expected swap/drop state.
module tb_gb_framebuffer;

   localparam logic [23:0] PAL0   = 24'hE0F8D0;
   localparam logic [23:0] PAL1   = 24'h88C070;
   localparam logic [23:0] PAL2   = 24'h346856;
   localparam logic [23:0] PAL3   = 24'h201808;
   localparam logic [23:0] BORDER = 24'h000000;
   localparam int          NPIX   = 160 * 144;

   logic        pixelClock = 1'b0;
   logic        reset = 1'b1;
   logic        frame_start = 1'b0;
   logic        pix_valid = 1'b0;
   logic [1:0]  pix_data = 2'd0;
   logic        rd_frame_start = 1'b0;
   logic [15:0] va = 16'h0000;
   logic [23:0] vd;
   logic [15:0] ppu_addr;
   logic        frame_ready;
   logic        disp_bank;
   logic [7:0]  dropped;

   int tests_run = 0;
   int tests_failed = 0;

   bit [1:0] model_mem [2][NPIX];
   bit       exp_disp = 1'b0;
   bit       exp_ready = 1'b0;
   int       exp_dropped = 0;
   int       rise_cnt = 0;
   bit       prev_ready = 1'b0;

   gb_framebuffer dut (
      .pixelClock     (pixelClock),
      .reset          (reset),
      .frame_start    (frame_start),
      .pix_valid      (pix_valid),
      .pix_data       (pix_data),
      .rd_frame_start (rd_frame_start),
      .va             (va),
      .vd             (vd),
      .ppu_addr       (ppu_addr),
      .frame_ready    (frame_ready),
      .disp_bank      (disp_bank),
      .dropped        (dropped)
   );

   always #5 pixelClock = ~pixelClock;

   function automatic logic [23:0] pal_of(input bit [1:0] c);
      case (c)
         2'd0:    return PAL0;
         2'd1:    return PAL1;
         2'd2:    return PAL2;
         default: return PAL3;
      endcase
   endfunction

   function automatic logic [23:0] exp_vd(input logic [15:0] a);
      int px;
      int py;
      px = int'(a[7:0]);
      py = int'(a[15:8]);
      if (px < 160 && py < 144) return pal_of(model_mem[exp_disp ? 1 : 0][py * 160 + px]);
      return BORDER;
   endfunction

   function automatic logic [15:0] rand_va();
      logic [15:0] r;
      r[15:8] = 8'($urandom_range(0, 150));
      r[7:0]  = 8'($urandom_range(0, 170));
      return r;
   endfunction

   // One clock; outputs sampled 1 time unit after the edge
   task automatic step();
      @(posedge pixelClock);
      #1;
      if (frame_ready && !prev_ready) rise_cnt++;
      prev_ready = frame_ready;
   endtask

   // Pulse frame_start (optionally with rd_frame_start) and update the model
   task automatic start_frame(input bit with_rd);
      frame_start    = 1'b1;
      rd_frame_start = with_rd;
      step();
      frame_start    = 1'b0;
      rd_frame_start = 1'b0;
      if (with_rd && exp_ready) begin
         exp_disp  = ~exp_disp;
         exp_ready = 1'b0;
      end else if (exp_ready) begin
         exp_ready = 1'b0;
         if (exp_dropped < 255) exp_dropped++;
      end
   endtask

   // Stream npix pixels; optionally read back the previously written address each cycle
   task automatic write_pixels(input int npix, input bit xcode, input bit check_reads);
      int          bk;
      bit [1:0]    c;
      logic [15:0] a;
      bk = exp_disp ? 0 : 1;
      for (int i = 0; i < npix; i++) begin
         c = xcode ? 2'(i % 160) : 2'($urandom_range(0, 3));
         pix_valid = 1'b1;
         pix_data  = c;
         model_mem[bk][i] = c;
         a = 16'h0000;
         if (check_reads) begin
            if (i == 0) a = rand_va();
            else a = {8'((i - 1) / 160), 8'((i - 1) % 160)};
            va = a;
         end
         step();
         if (check_reads) begin
            tests_run++;
            if (vd !== exp_vd(a)) begin
               tests_failed++;
               $display("FAIL read_during_write va=%h: vd=%h expected %h", a, vd, exp_vd(a));
            end
         end
      end
      pix_valid = 1'b0;
      if (npix == NPIX) exp_ready = 1'b1;
      $display("[TB] wrote %0d pixels into bank %0d", npix, bk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      va    = 16'h0000;
      repeat (3) step();
      reset = 1'b0;
      prev_ready = 1'b0;
      tests_run++;
      if (vd !== 24'h000000) begin tests_failed++; $display("FAIL reset_vd: vd=%h expected 000000", vd); end
      tests_run++;
      if (disp_bank !== 1'b0) begin tests_failed++; $display("FAIL reset_disp_bank: got %b expected 0", disp_bank); end
      tests_run++;
      if (frame_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_ready: got %b expected 0", frame_ready); end
      tests_run++;
      if (dropped !== 8'd0) begin tests_failed++; $display("FAIL reset_dropped: got %0d expected 0", dropped); end
      tests_run++;
      if (ppu_addr !== 16'h0000) begin tests_failed++; $display("FAIL reset_ppu_addr: got %h expected 0000", ppu_addr); end
      $display("[TB] reset checked");
   endtask

   task automatic test_full_frame();
      rise_cnt = 0;
      start_frame(1'b0);
      write_pixels(NPIX, 1'b1, 1'b0);
      tests_run++;
      if (frame_ready !== 1'b1) begin tests_failed++; $display("FAIL full_frame_ready: got %b expected 1", frame_ready); end
      tests_run++;
      if (ppu_addr !== {8'd143, 8'd159}) begin tests_failed++; $display("FAIL full_frame_ppu_addr: got %h expected 8f9f", ppu_addr); end
      tests_run++;
      if (rise_cnt !== 1) begin tests_failed++; $display("FAIL full_frame_rises: got %0d expected 1", rise_cnt); end
      rd_frame_start = 1'b1;
      va = {8'd0, 8'd3};
      step();
      rd_frame_start = 1'b0;
      exp_disp  = ~exp_disp;
      exp_ready = 1'b0;
      tests_run++;
      if (disp_bank !== 1'b1) begin tests_failed++; $display("FAIL swap_disp_bank: got %b expected 1", disp_bank); end
      tests_run++;
      if (frame_ready !== 1'b0) begin tests_failed++; $display("FAIL swap_frame_ready: got %b expected 0", frame_ready); end
      step();
      tests_run++;
      if (vd !== PAL3) begin tests_failed++; $display("FAIL swap_read_x3: vd=%h expected %h", vd, PAL3); end
      $display("[TB] swap to bank %0d", exp_disp);
   endtask

   task automatic test_border();
      logic [15:0] a;
      va = {8'd143, 8'd160};
      step();
      tests_run++;
      if (vd !== BORDER) begin tests_failed++; $display("FAIL border_x160: vd=%h expected %h", vd, BORDER); end
      va = {8'd144, 8'd0};
      step();
      tests_run++;
      if (vd !== BORDER) begin tests_failed++; $display("FAIL border_y144: vd=%h expected %h", vd, BORDER); end
      va = {8'd143, 8'd159};
      step();
      tests_run++;
      if (vd !== PAL3) begin tests_failed++; $display("FAIL last_pixel: vd=%h expected %h", vd, PAL3); end
      for (int i = 0; i < 64; i++) begin
         a  = rand_va();
         va = a;
         step();
         tests_run++;
         if (vd !== exp_vd(a)) begin tests_failed++; $display("FAIL random_read va=%h: vd=%h expected %h", a, vd, exp_vd(a)); end
      end
      // Scanout frame boundary with nothing waiting must not swap
      rd_frame_start = 1'b1;
      step();
      rd_frame_start = 1'b0;
      tests_run++;
      if (disp_bank !== exp_disp) begin tests_failed++; $display("FAIL idle_rd_frame_start: disp_bank=%b expected %b", disp_bank, exp_disp); end
      $display("[TB] border and random reads checked");
   endtask

   task automatic test_drop();
      logic [15:0] a;
      start_frame(1'b0);
      write_pixels(NPIX, 1'b0, 1'b0);
      tests_run++;
      if (frame_ready !== 1'b1) begin tests_failed++; $display("FAIL drop_pre_ready: got %b expected 1", frame_ready); end
      start_frame(1'b0);
      tests_run++;
      if (dropped !== 8'(exp_dropped)) begin tests_failed++; $display("FAIL drop_count: got %0d expected %0d", dropped, exp_dropped); end
      tests_run++;
      if (frame_ready !== 1'b0) begin tests_failed++; $display("FAIL drop_frame_ready: got %b expected 0", frame_ready); end
      tests_run++;
      if (disp_bank !== exp_disp) begin tests_failed++; $display("FAIL drop_disp_bank: got %b expected %b", disp_bank, exp_disp); end
      for (int i = 0; i < 16; i++) begin
         a  = rand_va();
         va = a;
         step();
         tests_run++;
         if (vd !== exp_vd(a)) begin tests_failed++; $display("FAIL drop_front_read va=%h: vd=%h expected %h", a, vd, exp_vd(a)); end
      end
      $display("[TB] drop checked, dropped=%0d", exp_dropped);
   endtask

   task automatic test_restart();
      rise_cnt = 0;
      start_frame(1'b0);
      write_pixels(500, 1'b0, 1'b0);
      tests_run++;
      if (frame_ready !== 1'b0) begin tests_failed++; $display("FAIL partial_frame_ready: got %b expected 0", frame_ready); end
      tests_run++;
      if (ppu_addr !== {8'd3, 8'd20}) begin tests_failed++; $display("FAIL partial_ppu_addr: got %h expected 0314", ppu_addr); end
      start_frame(1'b0);
      write_pixels(NPIX, 1'b0, 1'b0);
      tests_run++;
      if (rise_cnt !== 1) begin tests_failed++; $display("FAIL restart_rises: got %0d expected 1", rise_cnt); end
      tests_run++;
      if (frame_ready !== 1'b1) begin tests_failed++; $display("FAIL restart_ready: got %b expected 1", frame_ready); end
      tests_run++;
      if (dropped !== 8'(exp_dropped)) begin tests_failed++; $display("FAIL restart_dropped: got %0d expected %0d", dropped, exp_dropped); end
      $display("[TB] restart after partial frame checked");
   endtask

   task automatic test_back_to_back();
      start_frame(1'b1);
      tests_run++;
      if (disp_bank !== exp_disp) begin tests_failed++; $display("FAIL b2b_disp_bank: got %b expected %b", disp_bank, exp_disp); end
      tests_run++;
      if (dropped !== 8'(exp_dropped)) begin tests_failed++; $display("FAIL b2b_dropped: got %0d expected %0d", dropped, exp_dropped); end
      tests_run++;
      if (frame_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_frame_ready: got %b expected 0", frame_ready); end
      va = 16'h0000;
      step();
      tests_run++;
      if (vd !== exp_vd(16'h0000)) begin tests_failed++; $display("FAIL b2b_origin: vd=%h expected %h", vd, exp_vd(16'h0000)); end
      write_pixels(100, 1'b0, 1'b1);
      tests_run++;
      if (ppu_addr !== {8'd0, 8'd100}) begin tests_failed++; $display("FAIL b2b_ppu_addr: got %h expected 0064", ppu_addr); end
      $display("[TB] simultaneous swap and frame_start checked");
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_border();
      test_drop();
      test_restart();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
